// File: rtl/q2_sequencer.sv
// Q2 CPU timing/state generator: FETCH, optional DEREF, LOAD, bit-serial ALU pass, EXEC.
// Each machine cycle is a settle phase held while ready=0, then a one-clock ws strobe.
module q2_sequencer #(
  parameter int ALU_BITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  input  logic       ready,
  input  logic [7:0] dbus,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       ws,
  output logic       o0,
  output logic       o1,
  output logic       o2,
  output logic       deref,
  output logic       halted
);

  localparam int CW = $clog2(ALU_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(ALU_BITS - 2);

  typedef enum logic [3:0] {
    ST_FETCH    = 4'b0000,
    ST_DEREF    = 4'b0001,
    ST_LOAD     = 4'b0010,
    ST_EXEC     = 4'b0011,
    ST_ALU      = 4'b0100,
    ST_ALU_LAST = 4'b1100
  } state_e;

  state_e        state_q, state_d;
  logic          strobe_q, strobe_d;
  logic [2:0]    op_q, op_d;
  logic          deref_q, deref_d;
  logic          halted_q, halted_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q;
  logic          run_rise;

  // Only the opcode and indirect bits of the instruction byte are decoded here.
  logic unused_dbus;
  assign unused_dbus = ^{dbus[7], dbus[2:0]};

  assign run_rise = run & ~run_q;

  always_comb begin
    state_d  = state_q;
    strobe_d = strobe_q;
    op_d     = op_q;
    deref_d  = deref_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    if (halted_q) begin
      if (step || run_rise) halted_d = 1'b0;
    end else if (!strobe_q) begin
      if (ready) strobe_d = 1'b1;
    end else begin
      strobe_d = 1'b0;
      case (state_q)
        ST_FETCH: begin
          // Route on the byte being latched, not the previous instruction's bits.
          op_d    = dbus[6:4];
          deref_d = dbus[3];
          if (dbus[3])      state_d = ST_DEREF;
          else if (!dbus[6]) state_d = ST_LOAD;
          else              state_d = ST_EXEC;
        end
        ST_DEREF: state_d = op_q[2] ? ST_EXEC : ST_LOAD;
        ST_LOAD: begin
          cnt_d   = '0;
          state_d = ST_ALU;
        end
        ST_ALU: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = ST_ALU_LAST;
        end
        ST_ALU_LAST: begin
          cnt_d   = '0;
          state_d = ST_EXEC;
        end
        ST_EXEC: begin
          state_d  = ST_FETCH;
          halted_d = (op_q == 3'b100) || !run;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      strobe_q <= 1'b0;
      op_q     <= '0;
      deref_q  <= 1'b0;
      halted_q <= 1'b1;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      strobe_q <= strobe_d;
      op_q     <= op_d;
      deref_q  <= deref_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
      run_q    <= run;
    end
  end

  assign {s3, s2, s1, s0} = state_q;
  assign ws               = strobe_q;
  assign {o2, o1, o0}     = op_q;
  assign deref            = deref_q;
  assign halted           = halted_q;

endmodule

// File: tb/tb_q2_sequencer.sv
// Bench for q2_sequencer: instances with ALU_BITS=8 and ALU_BITS=2 against an instruction-level model.
`timescale 1ns/1ps
module tb_q2_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run, step, ready;
  logic [7:0] dbus;
  logic [1:0] s0, s1, s2, s3, ws, o0, o1, o2, dr, hl;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  q2_sequencer #(.ALU_BITS(8)) u8 (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .ready(ready), .dbus(dbus),
    .s0(s0[0]), .s1(s1[0]), .s2(s2[0]), .s3(s3[0]), .ws(ws[0]),
    .o0(o0[0]), .o1(o1[0]), .o2(o2[0]), .deref(dr[0]), .halted(hl[0])
  );

  q2_sequencer #(.ALU_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .ready(ready), .dbus(dbus),
    .s0(s0[1]), .s1(s1[1]), .s2(s2[1]), .s3(s3[1]), .ws(ws[1]),
    .o0(o0[1]), .o1(o1[1]), .o2(o2[1]), .deref(dr[1]), .halted(hl[1])
  );

  // Model: position within the current instruction's list of machine cycles.
  typedef struct packed {
    logic [7:0] idx;
    logic       stb;
    logic [2:0] o;
    logic       dr;
    logic       halt;
  } mst_t;

  localparam mst_t MST_RST = '{idx: 8'd0, stb: 1'b0, o: 3'd0, dr: 1'b0, halt: 1'b1};

  mst_t m [2];
  logic m_runp;

  function automatic int nb(int k);
    return (k == 0) ? 8 : 2;
  endfunction

  function automatic int cyc_len(int n, logic drf, logic o2f);
    return 1 + (drf ? 1 : 0) + (o2f ? 1 : n + 2);
  endfunction

  function automatic int cyc_state(int n, logic drf, logic o2f, int idx);
    int j;
    if (idx == 0) return 0;
    if (drf && idx == 1) return 1;
    j = idx - 1 - (drf ? 1 : 0);
    if (o2f) return 3;
    if (j == 0) return 2;
    if (j < n) return 4;
    if (j == n) return 12;
    return 3;
  endfunction

  function automatic mst_t model_step(mst_t c, int n, logic wake, logic rdy, logic rn, logic [7:0] db);
    mst_t x;
    x = c;
    if (c.halt) begin
      if (wake) x.halt = 1'b0;
    end else if (!c.stb) begin
      x.stb = rdy;
    end else begin
      x.stb = 1'b0;
      if (c.idx == 8'd0) begin
        x.o  = db[6:4];
        x.dr = db[3];
      end
      x.idx = c.idx + 8'd1;
      if (int'(x.idx) == cyc_len(n, x.dr, x.o[2])) begin
        x.idx = 8'd0;
        if (x.o == 3'b100 || !rn) x.halt = 1'b1;
      end
    end
    return x;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) m[k] <= MST_RST;
      m_runp <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++)
        m[k] <= model_step(m[k], nb(k), step || (run && !m_runp), ready, run, dbus);
      m_runp <= run;
    end
  end

  function automatic logic [9:0] exp_vec(int k);
    logic [3:0] s;
    s = 4'(cyc_state(nb(k), m[k].dr, m[k].o[2], int'(m[k].idx)));
    return {s, m[k].stb, m[k].o, m[k].dr, m[k].halt};
  endfunction

  function automatic logic [9:0] dut_vec(int k);
    return {s3[k], s2[k], s1[k], s0[k], ws[k], o2[k], o1[k], o0[k], dr[k], hl[k]};
  endfunction

  function automatic logic [3:0] st(int k);
    return {s3[k], s2[k], s1[k], s0[k]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("model_u8", 32'(dut_vec(0)), 32'(exp_vec(0)));
    chk("model_u2", 32'(dut_vec(1)), 32'(exp_vec(1)));
  endtask

  int exp_a [25] = '{0,0,1,1,2,2,4,4,4,4,4,4,4,4,4,4,4,4,4,4,12,12,3,3,0};
  int exp_f [11] = '{0,0,2,2,4,4,12,12,3,3,0};
  int cnt_ws, cnt_run;

  initial begin
    run = 1'b0; step = 1'b0; ready = 1'b1; dbus = 8'h2A;
    #1 rst_n = 1'b0;
    #3;
    chk("reset_u8", 32'(dut_vec(0)), 32'h001);
    chk("reset_u2", 32'(dut_vec(1)), 32'h001);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    // Indirect ALU instruction 0x2A from a rising edge of run.
    run = 1'b1;
    tick();
    chk("run_rise_clears_halt", 32'(hl[0]), 32'd0);
    for (int i = 0; i < 25; i++) begin
      if (i > 0) tick();
      chk("trace_2A", 32'({st(0), ws[0]}), 32'(exp_a[i] * 2 + (i % 2)));
    end
    chk("latched_2A", 32'({o2[0], o1[0], o0[0], dr[0]}), 32'b0101);

    // Store/jump 0x60: FETCH then EXEC only.
    dbus = 8'h60;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("trace_60", 32'({st(0), ws[0]}), 32'((i >= 2 && i <= 3 ? 3 : 0) * 2 + (i % 2)));
    end
    chk("latched_60", 32'({o2[0], o1[0], o0[0]}), 32'b110);

    // HALT opcode with run held high.
    dbus = 8'h40;
    for (int i = 1; i < 5; i++) tick();
    chk("halt_op_halted", 32'({st(0), hl[0]}), 32'b0000_1);
    cnt_ws = 0; cnt_run = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt_ws += int'(ws[0]);
      cnt_run += int'(!hl[0]);
    end
    chk("halt_hold_ws", 32'(cnt_ws), 32'd0);
    chk("halt_hold_halted", 32'(cnt_run), 32'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_clears_halt", 32'(hl[0]), 32'd0);
    cnt_ws = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      cnt_ws += int'(ws[0]);
    end
    chk("step_one_instr_ws", 32'(cnt_ws), 32'd2);
    chk("step_rehalt", 32'(hl[0]), 32'd1);

    // Memory wait in LOAD settle, then reset mid-ALU.
    dbus = 8'h20;
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
    chk("d_idx0", 32'({st(0), ws[0], hl[0]}), 32'b0000_0_0);
    tick();
    chk("d_idx1", 32'({st(0), ws[0]}), 32'b0000_1);
    tick();
    chk("d_load_settle", 32'({st(0), ws[0]}), 32'b0010_0);
    ready = 1'b0;
    for (int i = 3; i < 8; i++) begin
      tick();
      chk("d_wait_hold", 32'({st(0), ws[0]}), 32'b0010_0);
    end
    ready = 1'b1;
    tick();
    chk("d_strobe_after_ready", 32'({st(0), ws[0]}), 32'b0010_1);
    for (int i = 9; i < 16; i++) tick();
    chk("d_alu_cnt3", 32'({st(0), ws[0]}), 32'b0100_0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_u8", 32'(dut_vec(0)), 32'h001);
    chk("async_reset_u2", 32'(dut_vec(1)), 32'h001);
    tick();
    rst_n = 1'b1;
    tick();
    chk("e_restart", 32'({st(0), ws[0], hl[0]}), 32'b0000_0_0);
    tick();
    chk("e_fetch_strobe", 32'({st(0), ws[0]}), 32'b0000_1);
    tick();
    chk("e_load", 32'({st(0), ws[0]}), 32'b0010_0);

    // ALU_BITS=2 instance, run dropped during ALU.
    #2 rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) begin
      if (i > 0) tick();
      chk("trace_u2", 32'({st(1), ws[1]}), 32'(exp_f[i] * 2 + (i % 2)));
      if (i == 5) run = 1'b0;
    end
    chk("u2_run_drop_halt", 32'(hl[1]), 32'd1);

    // Randomized traffic against the model.
    run = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      ready = ($urandom_range(0, 3) != 0);
      step  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) run = ~run;
      dbus = 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
